// File: rtl/cart_pkg.sv
// Shared definitions for the DMG cartridge bus: FSM states, default timing, /CS decode window.
package cart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold
   } cart_state_e;

   localparam int unsigned DEF_SETUP_CYC  = 2;
   localparam int unsigned DEF_STROBE_CYC = 4;
   localparam int unsigned DEF_HOLD_CYC   = 2;

   // External-RAM / WRAM-echo window that selects the cartridge /CS line
   localparam logic [15:0] CS_LO = 16'hA000;
   localparam logic [15:0] CS_HI = 16'hFDFF;

   function automatic logic cs_hit(input logic [15:0] addr);
      return (addr >= CS_LO) && (addr <= CS_HI);
   endfunction

endpackage

// File: rtl/cart_bus_timing.sv
// Turns single-cycle read/write request pulses into a timed setup/strobe/hold cartridge bus cycle.
module cart_bus_timing
   import cart_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
   parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
   parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cart_a,
   input  logic [7:0]  cart_dout,
   input  logic        cart_wr,
   input  logic        cart_rd,
   output logic [7:0]  cart_din,
   output logic        cart_busy,
   output logic [15:0] gb_a,
   output logic [7:0]  gb_d_out,
   input  logic [7:0]  gb_d_in,
   output logic        gb_d_oe,
   output logic        gb_rd_n,
   output logic        gb_wr_n,
   output logic        gb_cs_n
);

   // Phase counter reload values: a phase of length L counts L-1 down to 0
   localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

   cart_state_e state_q;
   logic [3:0]  cnt_q;
   logic        is_wr_q;
   logic [15:0] gb_a_q;
   logic [7:0]  gb_d_out_q;
   logic [7:0]  cart_din_q;
   logic        gb_d_oe_q;
   logic        gb_rd_n_q;
   logic        gb_wr_n_q;
   logic        gb_cs_n_q;
   logic        busy_q;

   // Bus-cycle FSM; every bus-facing output is a register so strobes cannot glitch
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         is_wr_q    <= 1'b0;
         gb_a_q     <= 16'h0000;
         gb_d_out_q <= 8'h00;
         cart_din_q <= 8'h00;
         gb_d_oe_q  <= 1'b0;
         gb_rd_n_q  <= 1'b1;
         gb_wr_n_q  <= 1'b1;
         gb_cs_n_q  <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cart_wr || cart_rd) begin
                  // Write wins when both pulses coincide
                  is_wr_q    <= cart_wr;
                  gb_a_q     <= cart_a;
                  gb_d_out_q <= cart_dout;
                  gb_d_oe_q  <= cart_wr;
                  gb_cs_n_q  <= ~cs_hit(cart_a);
                  busy_q     <= 1'b1;
                  cnt_q      <= SETUP_LOAD;
                  state_q    <= StSetup;
               end
            end
            StSetup: begin
               if (cnt_q == 4'd0) begin
                  gb_wr_n_q <= ~is_wr_q;
                  gb_rd_n_q <= is_wr_q;
                  cnt_q     <= STROBE_LOAD;
                  state_q   <= StStrobe;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StStrobe: begin
               if (cnt_q == 4'd0) begin
                  // Sample the bus on the edge that raises /RD
                  if (!is_wr_q) begin
                     cart_din_q <= gb_d_in;
                  end
                  gb_wr_n_q <= 1'b1;
                  gb_rd_n_q <= 1'b1;
                  cnt_q     <= HOLD_LOAD;
                  state_q   <= StHold;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StHold: begin
               if (cnt_q == 4'd0) begin
                  // Address and data stay parked to avoid needless bus toggling
                  gb_d_oe_q <= 1'b0;
                  gb_cs_n_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cart_din  = cart_din_q;
   assign cart_busy = busy_q;
   assign gb_a      = gb_a_q;
   assign gb_d_out  = gb_d_out_q;
   assign gb_d_oe   = gb_d_oe_q;
   assign gb_rd_n   = gb_rd_n_q;
   assign gb_wr_n   = gb_wr_n_q;
   assign gb_cs_n   = gb_cs_n_q;

endmodule

// File: doc/cart_bus_timing.md
# cart_bus_timing

Downstream of the SPI command decoder: converts its single-cycle `cart_rd` / `cart_wr` request pulses into a correctly timed DMG cartridge-bus cycle. A cycle has three phases: address/data setup, a `/RD` or `/WR` strobe, and hold. The block decodes `/CS`, drives the data-bus output enable, and latches read data for the decoder. It reports `cart_busy` for the whole bus cycle.

## Interface
Parameters:
- `SETUP_CYC`, default 2: clk cycles of address/data setup before the strobe; legal range 1..15.
- `STROBE_CYC`, default 4: clk cycles the strobe is held low; legal range 1..15.
- `HOLD_CYC`, default 2: clk cycles of address/data/`/CS` hold after the strobe; legal range 1..15.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `cart_a`, in, 16: request address from the decoder.
- `cart_dout`, in, 8: write data from the decoder.
- `cart_wr`, in, 1: single-cycle write request pulse.
- `cart_rd`, in, 1: single-cycle read request pulse.
- `cart_din`, out, 8: data returned by the last completed read.
- `cart_busy`, out, 1: high while a bus cycle is in progress.
- `gb_a`, out, 16: cartridge address bus.
- `gb_d_out`, out, 8: cartridge data bus, output value.
- `gb_d_in`, in, 8: cartridge data bus, input value.
- `gb_d_oe`, out, 1: data bus output enable (1 = drive).
- `gb_rd_n`, out, 1: `/RD`, active low.
- `gb_wr_n`, out, 1: `/WR`, active low.
- `gb_cs_n`, out, 1: `/CS`, active low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- A 4-bit down-counter loads phase length minus 1 on entry to each phase. The phase ends on the cycle the counter reads 0.
- IDLE:
  - On `cart_wr | cart_rd`, latch `cart_a` into `gb_a`, `cart_dout` into `gb_d_out`, and the direction (`is_wr`). Go to SETUP.
  - If `cart_wr` and `cart_rd` are high in the same cycle, the write wins and the read is dropped.
- SETUP:
  - `gb_a` is stable.
  - `gb_cs_n` = 0 iff the latched address is in 0xA000..0xFDFF.
  - `gb_d_oe` = `is_wr`.
  - Both strobes are high.
- STROBE: `gb_wr_n` = 0 (write) or `gb_rd_n` = 0 (read); everything else held.
- Read capture: on the final STROBE cycle, register `gb_d_in` into `cart_din`. `cart_din` otherwise holds its value; writes never change it.
- HOLD: both strobes high; `gb_a`, `gb_d_out`, `gb_d_oe` and `gb_cs_n` held. Return to IDLE.
- IDLE outputs:
  - `gb_rd_n` = `gb_wr_n` = `gb_cs_n` = 1 and `gb_d_oe` = 0.
  - `gb_a` and `gb_d_out` keep their last values, to avoid bus toggling.
- Requests arriving outside IDLE are ignored. The upstream decoder is required to honour `cart_busy`.
- Reset values:
  - State IDLE.
  - `gb_a` = 0x0000, `gb_d_out` = 0x00, `cart_din` = 0x00.
  - Strobes and `/CS` = 1, `gb_d_oe` = 0, `cart_busy` = 0.
- Reset mid-cycle: at the next edge all strobes, `/CS` and `gb_d_oe` deassert. No read data is captured and the transfer is abandoned.

## Timing
- Request pulse sampled at edge N.
  - SETUP occupies cycles N+1 .. N+SETUP_CYC.
  - STROBE follows for STROBE_CYC cycles.
  - HOLD follows for HOLD_CYC cycles.
- `cart_busy` = (state != IDLE), all outputs registered. It rises at N+1 and stays high for SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (default 8).
- Read data appears on `cart_din` on the first HOLD cycle. It stays valid until the next read's capture.
- Back-to-back: a new request is accepted on the first cycle `cart_busy` is low. Minimum request spacing is busy length + 1 cycles.
- `gb_a`, `gb_d_out` and `/CS` are stable strictly before the strobe falls and after it rises. There is never a glitch on `/RD` or `/WR`.
- Counter width is 4 bits. A parameter value of 1 gives a single-cycle phase, with no wrap or underflow.

## Structure
- Shared package `cart_pkg`:
  - FSM state enum.
  - Default timing constants.
  - `/CS` decode bounds `CS_LO` = 16'hA000 and `CS_HI` = 16'hFDFF, shared with any future bus monitor.
- Single module with no sub-modules. The phase counter is inline.

## Test plan
- Write 0x5A to 0x2000 with defaults:
  - `gb_d_oe` = 1 for 8 cycles.
  - `gb_wr_n` low exactly cycles 3–6 after the request.
  - `gb_cs_n` stays 1.
  - `cart_busy` high for 8 cycles.
- Read 0xA123 with `gb_d_in` = 0x3C:
  - `gb_cs_n` = 0 for the whole cycle.
  - `gb_rd_n` low for 4 cycles.
  - `cart_din` = 0x3C from the first HOLD cycle.
  - `gb_d_oe` stays 0 throughout.
- `gb_d_in` changed to 0x77 after the capture edge: `cart_din` remains 0x3C. A subsequent write leaves `cart_din` unchanged.
- `cart_rd` and `cart_wr` pulsed together: a write cycle only. A request pulsed mid-cycle is ignored, and the bus output matches a single transfer.
- Back-to-back read then write, the second request issued on the first non-busy cycle: both are executed, with the strobes separated by exactly HOLD_CYC + 1 + SETUP_CYC cycles.
- `rst` asserted during STROBE of a read:
  - All strobes, `/CS` and `gb_d_oe` inactive one edge later.
  - `cart_din` = 0x00 and `gb_a` = 0x0000.
  - The next request behaves normally.
